kyber512_encaps_kem: RTL and testbench
======================================

// Module: kyber512_encaps_kem
// PURPOSE
//  Kyber512 KEM encapsulation top, the sender-side counterpart of the decapsulation top.
//  Sequences three stages: pre-hash, IND-CPA encryption and post-hash.
//   - Pre-hash: m=H(coins), (Kbar,r)=G(m||H(pk)).
//   - Encryption: IND-CPA encryption core run in enc mode (mux_enc_dec=0).
//   - Post-hash: K=KDF(Kbar||H(c)).
//  Emits the ciphertext and the 32-byte shared secret. Sits under the AXI wrapper.
// PARAMETERS
//  KYBER_K          2      module rank
//  KYBER_N          256    polynomial length
//  KYBER_Q          3329   modulus
//  PK_BYTES         800    public key bytes
//  CT_BYTES         736    ciphertext bytes (same as decaps input)
//  SS_BYTES         32     shared secret bytes
//  CYC_W            24     width of the cycle counter
// PORTS
//  clk              in   1            clock, rising edge
//  rst_n            in   1            asynchronous reset, active-low
//  enable           in   1            start pulse, sampled in IDLE only
//  i_PK             in   8*PK_BYTES   public key, held stable while Cal_flag=1
//  i_Coins          in   256          random seed m0, held stable while Cal_flag=1
//  Cal_flag         out  1            busy
//  Encryption_Done  out  1            sticky done
//  o_Ct             out  8*CT_BYTES   ciphertext, registered
//  o_SharedSecret   out  8*SS_BYTES   K, registered
//  o_cycles         out  CYC_W        cycles of the last run
//  cstate_flag      out  3            current state encoding
// BEHAVIOUR
//  Reset: state IDLE; Cal_flag=0, Encryption_Done=0, o_Ct=0, o_SharedSecret=0, o_cycles=0.
//   Sub-block enables are 0.
//  States: IDLE=0, PRE_H=1, CPA_ENC=2, POST_H=3, DONE=4. Codes 5-7 go to IDLE next cycle.
//  IDLE: enable=1 -> PRE_H.
//   - In the same edge: Cal_flag<=1, Encryption_Done<=0, o_cycles<=0.
//   - Pulse hash-unit enable for 1 cycle, mode=0.
//  PRE_H: on hash done -> CPA_ENC.
//   - Latch Kbar=oKr[255:0] and r=oKr[511:256] into internal regs.
//   - Pulse CPA enable for 1 cycle, mux_enc_dec=0, msg=m, coins=r.
//  CPA_ENC: on enc done -> POST_H.
//   - Latch the ciphertext into o_Ct.
//   - Pulse hash enable, mode=1, iBuf_Low=Kbar, iCt=o_Ct.
//  POST_H: on hash done -> DONE; latch o_SharedSecret.
//  DONE: one cycle, then IDLE.
//   - Encryption_Done<=1 (held until the next start); Cal_flag<=0.
//   - o_Ct/o_SharedSecret hold until the next start.
//  All enables are exactly 1-cycle pulses, asserted on the transition edge. Never re-pulse within a state.
//  enable while Cal_flag=1: ignored, no restart, outputs unaffected.
//  Done from the wrong sub-block or in the wrong state: ignored.
//  o_cycles increments every cycle while Cal_flag=1. It saturates at all-ones and never wraps.
//  rst_n low mid-run: immediate abort to reset values. The next start behaves like the first run.
//  enable in the same cycle as DONE: ignored. The FSM must be in IDLE to accept it.
// TESTING
//  T1 KAT vector 0:
//   - Stimulus: load pk/coins, pulse enable.
//   - Required: o_Ct and o_SharedSecret match the reference ct/ss; Encryption_Done=1; Cal_flag=0.
//  T2 round trip:
//   - Stimulus: feed the T1 ct plus the matching sk to the decaps top.
//   - Required: its ss equals o_SharedSecret; Verify_fail=0.
//  T3 busy protection:
//   - Stimulus: pulse enable every 50 cycles during a run.
//   - Required: a single run; o_cycles equals the T1 value; cstate_flag sequence 0,1,2,3,4,0.
//  T4 reset mid-run:
//   - Stimulus: rst_n=0 during CPA_ENC, then a T1 restart.
//   - Required: all outputs 0 during reset; the restart reproduces T1 exactly.
//  T5 back-to-back:
//   - Stimulus: two vectors, enable pulsed on the first IDLE cycle after done.
//   - Required: Encryption_Done drops on the start edge; the second outputs are correct.
//  T6 saturation:
//   - Stimulus: CYC_W=4 build.
//   - Required: o_cycles=15 at done; no wrap.

Source files
------------

// File: rtl/kyber512_encaps_kem_if.sv
// rtl/kyber512_encaps_kem_if.sv - request/response bus between the encaps sequencer and its hash / IND-CPA engines
interface kyber512_encaps_kem_if #(
    parameter int PK_BYTES = 800,
    parameter int CT_BYTES = 736,
    parameter int SEED_W   = 256
);
    logic                    hash_en;
    logic                    hash_mode;
    logic [SEED_W-1:0]       hash_coins;
    logic [8*PK_BYTES-1:0]   hash_pk;
    logic [SEED_W-1:0]       hash_buf_low;
    logic [8*CT_BYTES-1:0]   hash_ct;
    logic                    hash_done;
    logic [SEED_W-1:0]       hash_m;
    logic [2*SEED_W-1:0]     hash_kr;

    logic                    cpa_en;
    logic                    cpa_mux_enc_dec;
    logic [SEED_W-1:0]       cpa_msg;
    logic [SEED_W-1:0]       cpa_coins;
    logic [8*PK_BYTES-1:0]   cpa_pk;
    logic                    cpa_done;
    logic [8*CT_BYTES-1:0]   cpa_ct;

    modport master (
        output hash_en, hash_mode, hash_coins, hash_pk, hash_buf_low, hash_ct,
        input  hash_done, hash_m, hash_kr,
        output cpa_en, cpa_mux_enc_dec, cpa_msg, cpa_coins, cpa_pk,
        input  cpa_done, cpa_ct
    );

    modport slave (
        input  hash_en, hash_mode, hash_coins, hash_pk, hash_buf_low, hash_ct,
        output hash_done, hash_m, hash_kr,
        input  cpa_en, cpa_mux_enc_dec, cpa_msg, cpa_coins, cpa_pk,
        output cpa_done, cpa_ct
    );
endinterface

// File: rtl/kyber512_encaps_kem.sv
// rtl/kyber512_encaps_kem.sv - Kyber512 encapsulation sequencer: pre-hash, IND-CPA encrypt, post-hash
module kyber512_encaps_kem #(
    parameter int KYBER_K  = 2,
    parameter int KYBER_N  = 256,
    parameter int KYBER_Q  = 3329,
    parameter int PK_BYTES = 800,
    parameter int CT_BYTES = 736,
    parameter int SS_BYTES = 32,
    parameter int CYC_W    = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [8*PK_BYTES-1:0]   i_PK,
    input  logic [KYBER_N-1:0]      i_Coins,
    output logic                    Cal_flag,
    output logic                    Encryption_Done,
    output logic [8*CT_BYTES-1:0]   o_Ct,
    output logic [8*SS_BYTES-1:0]   o_SharedSecret,
    output logic [CYC_W-1:0]        o_cycles,
    output logic [2:0]              cstate_flag,
    kyber512_encaps_kem_if.master   sub
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PRE_H   = 3'd1;
    localparam logic [2:0] S_CPA_ENC = 3'd2;
    localparam logic [2:0] S_POST_H  = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    if (8*PK_BYTES != KYBER_K*384*8 + KYBER_N || KYBER_Q >= 4096) begin : g_bad_params
        $error("kyber512_encaps_kem: public key size does not match rank/length");
    end

    logic [2:0]              state_q, state_d;
    logic                    cal_q, cal_d;
    logic                    done_q, done_d;
    logic                    hash_en_q, hash_en_d;
    logic                    hash_mode_q, hash_mode_d;
    logic                    cpa_en_q, cpa_en_d;
    logic [8*CT_BYTES-1:0]   ct_q, ct_d;
    logic [8*SS_BYTES-1:0]   ss_q, ss_d;
    logic [CYC_W-1:0]        cyc_q, cyc_d;
    logic [KYBER_N-1:0]      m_q, m_d;
    logic [KYBER_N-1:0]      kbar_q, kbar_d;
    logic [KYBER_N-1:0]      r_q, r_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cal_q       <= 1'b0;
            done_q      <= 1'b0;
            hash_en_q   <= 1'b0;
            hash_mode_q <= 1'b0;
            cpa_en_q    <= 1'b0;
            ct_q        <= '0;
            ss_q        <= '0;
            cyc_q       <= '0;
            m_q         <= '0;
            kbar_q      <= '0;
            r_q         <= '0;
        end else begin
            state_q     <= state_d;
            cal_q       <= cal_d;
            done_q      <= done_d;
            hash_en_q   <= hash_en_d;
            hash_mode_q <= hash_mode_d;
            cpa_en_q    <= cpa_en_d;
            ct_q        <= ct_d;
            ss_q        <= ss_d;
            cyc_q       <= cyc_d;
            m_q         <= m_d;
            kbar_q      <= kbar_d;
            r_q         <= r_d;
        end
    end

    // Each stage only listens to the done of the engine it started.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (enable)        state_d = S_PRE_H;
            S_PRE_H:   if (sub.hash_done) state_d = S_CPA_ENC;
            S_CPA_ENC: if (sub.cpa_done)  state_d = S_POST_H;
            S_POST_H:  if (sub.hash_done) state_d = S_DONE;
            S_DONE:                       state_d = S_IDLE;
            default:                      state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cal_d       = cal_q;
        done_d      = done_q;
        hash_en_d   = 1'b0;
        cpa_en_d    = 1'b0;
        hash_mode_d = hash_mode_q;
        ct_d        = ct_q;
        ss_d        = ss_q;
        m_d         = m_q;
        kbar_d      = kbar_q;
        r_d         = r_q;
        cyc_d       = (cal_q && !(&cyc_q)) ? cyc_q + CYC_W'(1) : cyc_q;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    cal_d       = 1'b1;
                    done_d      = 1'b0;
                    cyc_d       = '0;
                    hash_en_d   = 1'b1;
                    hash_mode_d = 1'b0;
                end
            end
            S_PRE_H: begin
                if (sub.hash_done) begin
                    m_d      = sub.hash_m;
                    kbar_d   = sub.hash_kr[KYBER_N-1:0];
                    r_d      = sub.hash_kr[2*KYBER_N-1:KYBER_N];
                    cpa_en_d = 1'b1;
                end
            end
            S_CPA_ENC: begin
                if (sub.cpa_done) begin
                    ct_d        = sub.cpa_ct;
                    hash_en_d   = 1'b1;
                    hash_mode_d = 1'b1;
                end
            end
            S_POST_H: begin
                if (sub.hash_done) ss_d = sub.hash_kr[8*SS_BYTES-1:0];
            end
            S_DONE: begin
                done_d = 1'b1;
                cal_d  = 1'b0;
            end
            default: ;
        endcase
    end

    // Engine operands come straight from the latched stage results, valid on the pulse cycle.
    assign sub.hash_en         = hash_en_q;
    assign sub.hash_mode       = hash_mode_q;
    assign sub.hash_coins      = i_Coins;
    assign sub.hash_pk         = i_PK;
    assign sub.hash_buf_low    = kbar_q;
    assign sub.hash_ct         = ct_q;
    assign sub.cpa_en          = cpa_en_q;
    assign sub.cpa_mux_enc_dec = 1'b0;
    assign sub.cpa_msg         = m_q;
    assign sub.cpa_coins       = r_q;
    assign sub.cpa_pk          = i_PK;

    assign Cal_flag        = cal_q;
    assign Encryption_Done = done_q;
    assign o_Ct            = ct_q;
    assign o_SharedSecret  = ss_q;
    assign o_cycles        = cyc_q;
    assign cstate_flag     = state_q;
endmodule

// File: tb/tb_kyber512_encaps_kem.sv
// tb/tb_kyber512_encaps_kem.sv - self-checking bench with toy hash/CPA engines and a reference encapsulation model
module tb_kyber512_encaps_kem;
    localparam int PKW = 6400;
    localparam int CTW = 5888;
    localparam int SW  = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, en, sel4;
    logic [PKW-1:0] pk;
    logic [SW-1:0]  coins;
    logic cal, done, cal4, done4;
    logic [CTW-1:0] ct, ct4;
    logic [SW-1:0]  ss, ss4;
    logic [23:0]    cyc;
    logic [3:0]     cyc4;
    logic [2:0]     cst, cst4;

    kyber512_encaps_kem_if bus ();
    kyber512_encaps_kem_if bus4 ();

    kyber512_encaps_kem dut (
        .clk(clk), .rst_n(rst_n), .enable(en & ~sel4), .i_PK(pk), .i_Coins(coins),
        .Cal_flag(cal), .Encryption_Done(done), .o_Ct(ct), .o_SharedSecret(ss),
        .o_cycles(cyc), .cstate_flag(cst), .sub(bus)
    );

    kyber512_encaps_kem #(.CYC_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .enable(en & sel4), .i_PK(pk), .i_Coins(coins),
        .Cal_flag(cal4), .Encryption_Done(done4), .o_Ct(ct4), .o_SharedSecret(ss4),
        .o_cycles(cyc4), .cstate_flag(cst4), .sub(bus4)
    );

    logic h_done, c_done;
    logic [SW-1:0]   h_m;
    logic [2*SW-1:0] h_kr;
    logic [CTW-1:0]  c_ct;
    assign bus.hash_done  = h_done;  assign bus4.hash_done = h_done;
    assign bus.hash_m     = h_m;     assign bus4.hash_m    = h_m;
    assign bus.hash_kr    = h_kr;    assign bus4.hash_kr   = h_kr;
    assign bus.cpa_done   = c_done;  assign bus4.cpa_done  = c_done;
    assign bus.cpa_ct     = c_ct;    assign bus4.cpa_ct    = c_ct;

    logic rq_hash_en, rq_hash_mode, rq_cpa_en, rq_cpa_mux;
    logic [SW-1:0]  rq_hash_coins, rq_hash_buf_low, rq_cpa_msg, rq_cpa_coins;
    logic [PKW-1:0] rq_hash_pk, rq_cpa_pk;
    logic [CTW-1:0] rq_hash_ct;
    assign rq_hash_en      = sel4 ? bus4.hash_en         : bus.hash_en;
    assign rq_hash_mode    = sel4 ? bus4.hash_mode       : bus.hash_mode;
    assign rq_hash_coins   = sel4 ? bus4.hash_coins      : bus.hash_coins;
    assign rq_hash_pk      = sel4 ? bus4.hash_pk         : bus.hash_pk;
    assign rq_hash_buf_low = sel4 ? bus4.hash_buf_low    : bus.hash_buf_low;
    assign rq_hash_ct      = sel4 ? bus4.hash_ct         : bus.hash_ct;
    assign rq_cpa_en       = sel4 ? bus4.cpa_en          : bus.cpa_en;
    assign rq_cpa_mux      = sel4 ? bus4.cpa_mux_enc_dec : bus.cpa_mux_enc_dec;
    assign rq_cpa_msg      = sel4 ? bus4.cpa_msg         : bus.cpa_msg;
    assign rq_cpa_coins    = sel4 ? bus4.cpa_coins       : bus.cpa_coins;
    assign rq_cpa_pk       = sel4 ? bus4.cpa_pk          : bus.cpa_pk;

    logic cal_s, done_s;
    logic [2:0]     cst_s;
    logic [CTW-1:0] ct_s;
    logic [SW-1:0]  ss_s;
    assign cal_s  = sel4 ? cal4  : cal;
    assign done_s = sel4 ? done4 : done;
    assign cst_s  = sel4 ? cst4  : cst;
    assign ct_s   = sel4 ? ct4   : ct;
    assign ss_s   = sel4 ? ss4   : ss;

    // Toy stand-ins for SHA3/IND-CPA: only distinctness of results matters here.
    function automatic logic [SW-1:0] rotl(input logic [SW-1:0] x, input int n);
        int k;
        k = n % SW;
        if (k == 0) return x;
        return (x << k) | (x >> (SW - k));
    endfunction

    function automatic logic [SW-1:0] f_h(input logic [SW-1:0] c);
        return rotl(c, 37) ^ {8{32'h9E3779B9}};
    endfunction

    function automatic logic [2*SW-1:0] f_g(input logic [SW-1:0] m, input logic [PKW-1:0] p);
        logic [SW-1:0] h;
        h = '0;
        for (int i = 0; i < PKW / SW; i++) h = h ^ rotl(p[i*SW +: SW], i + 1);
        return {rotl(m, 13) + h, m ^ h ^ {8{32'h5A5A0F0F}}};
    endfunction

    function automatic logic [CTW-1:0] f_enc(input logic [PKW-1:0] p, input logic [SW-1:0] m,
                                             input logic [SW-1:0] r);
        logic [CTW-1:0] c;
        for (int i = 0; i < CTW / SW; i++)
            c[i*SW +: SW] = p[i*SW +: SW] ^ rotl(r, i + 3) ^ (m + SW'(i));
        return c;
    endfunction

    function automatic logic [SW-1:0] f_kdf(input logic [SW-1:0] kbar, input logic [CTW-1:0] c);
        logic [SW-1:0] x;
        x = rotl(kbar, 7);
        for (int i = 0; i < CTW / SW; i++) x = x ^ rotl(c[i*SW +: SW], 2*i + 1);
        return x ^ {8{32'hC3A51E77}};
    endfunction

    task automatic ref_encaps(input logic [PKW-1:0] p, input logic [SW-1:0] c,
                              output logic [CTW-1:0] e_ct, output logic [SW-1:0] e_ss);
        logic [SW-1:0]   m;
        logic [2*SW-1:0] kr;
        m    = f_h(c);
        kr   = f_g(m, p);
        e_ct = f_enc(p, m, kr[2*SW-1:SW]);
        e_ss = f_kdf(kr[SW-1:0], e_ct);
    endtask

    int lat_fix;
    int hspur_req, cspur_req;

    function automatic int get_lat();
        return (lat_fix != 0) ? lat_fix : int'($urandom_range(20, 3));
    endfunction

    initial begin
        int cnt, spur_ack;
        logic [SW-1:0]   pm;
        logic [2*SW-1:0] pkr;
        cnt = 0; spur_ack = 0; h_done = 1'b0; h_m = '0; h_kr = '0; pm = '0; pkr = '0;
        forever begin
            @(negedge clk);
            h_done = 1'b0;
            if (!rst_n) cnt = 0;
            else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin h_done = 1'b1; h_m = pm; h_kr = pkr; end
            end else if (rq_hash_en) begin
                if (!rq_hash_mode) begin
                    pm  = f_h(rq_hash_coins);
                    pkr = f_g(pm, rq_hash_pk);
                end else begin
                    pm  = '0;
                    pkr = {{SW{1'b0}}, f_kdf(rq_hash_buf_low, rq_hash_ct)};
                end
                cnt = get_lat();
            end
            if (hspur_req != spur_ack) begin
                spur_ack = hspur_req; h_done = 1'b1; h_m = ~h_m; h_kr = ~h_kr;
            end
        end
    end

    initial begin
        int cnt, spur_ack;
        logic [CTW-1:0] pct;
        cnt = 0; spur_ack = 0; c_done = 1'b0; c_ct = '0; pct = '0;
        forever begin
            @(negedge clk);
            c_done = 1'b0;
            if (!rst_n) cnt = 0;
            else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin c_done = 1'b1; c_ct = pct; end
            end else if (rq_cpa_en) begin
                pct = f_enc(rq_cpa_pk, rq_cpa_msg, rq_cpa_coins);
                if (rq_cpa_mux) pct = ~pct;
                cnt = get_lat();
            end
            if (cspur_req != spur_ack) begin
                spur_ack = cspur_req; c_done = 1'b1; c_ct = ~c_ct;
            end
        end
    end

    int n_hash, n_cpa, cal_cnt, st_n;
    logic [2:0] st_log [4096];
    initial begin
        logic [2:0] last_st;
        n_hash = 0; n_cpa = 0; cal_cnt = 0; st_n = 0; last_st = 3'd0;
        forever begin
            @(negedge clk);
            if (rq_hash_en) n_hash++;
            if (rq_cpa_en)  n_cpa++;
            if (cal_s)      cal_cnt++;
            if (cst_s !== last_st) begin
                st_log[st_n % 4096] = cst_s; st_n++; last_st = cst_s;
            end
        end
    end

    int n_err, n_chk;
    int base_cal, base_h, base_c;

    task automatic chk(input string nm, input logic [CTW-1:0] act, input logic [CTW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (low 64 bits)", nm, act[63:0], exp[63:0]);
        end
    endtask

    task automatic chk_i(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic start_run(input logic [PKW-1:0] p, input logic [SW-1:0] c);
        pk = p; coins = c;
        base_cal = cal_cnt; base_h = n_hash; base_c = n_cpa;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic wait_run(input int poke);
        int t;
        t = 0;
        forever begin
            @(negedge clk);
            t++;
            if ((done_s && !cal_s) || t > 3000) break;
            en = (poke != 0 && t % poke == 0);
        end
        en = 1'b0;
        #1;
        if (t > 3000) begin
            n_chk++; n_err++;
            $display("FAIL run_timeout: no Encryption_Done within 3000 cycles");
        end
    endtask

    task automatic wait_state(input logic [2:0] s);
        int t;
        t = 0;
        while (cst_s !== s && t < 500) begin @(negedge clk); t++; end
        if (t >= 500) begin
            n_chk++; n_err++;
            $display("FAIL state_timeout: state %0d never reached", s);
        end
    endtask

    task automatic check_out(input string nm, input logic [CTW-1:0] e_ct, input logic [SW-1:0] e_ss);
        longint model;
        chk({nm, "_ct"}, ct_s, e_ct);
        chk({nm, "_ss"}, CTW'(ss_s), CTW'(e_ss));
        chk_i({nm, "_done"}, longint'(done_s), 1);
        chk_i({nm, "_cal"}, longint'(cal_s), 0);
        chk_i({nm, "_hash_pulses"}, n_hash - base_h, 2);
        chk_i({nm, "_cpa_pulses"}, n_cpa - base_c, 1);
        model = cal_cnt - base_cal;
        if (sel4) chk_i({nm, "_cycles"}, longint'(cyc4), (model > 15) ? 15 : model);
        else      chk_i({nm, "_cycles"}, longint'(cyc), (model > 24'hFFFFFF) ? 24'hFFFFFF : model);
    endtask

    typedef struct {
        logic [PKW-1:0] pk;
        logic [SW-1:0]  coins;
        logic [CTW-1:0] ct;
        logic [SW-1:0]  ss;
    } vec_t;
    vec_t vt [4];

    initial begin
        longint cyc_ref;
        int tr_base;
        int exp_tr [5];
        exp_tr = '{1, 2, 3, 4, 0};
        n_err = 0; n_chk = 0;
        rst_n = 1'b0; en = 1'b0; sel4 = 1'b0; pk = '0; coins = '0;
        lat_fix = 0; hspur_req = 0; cspur_req = 0;
        repeat (3) @(negedge clk);
        chk_i("rst_cal", longint'(cal), 0);
        chk_i("rst_done", longint'(done), 0);
        chk("rst_ct", ct, '0);
        chk("rst_ss", CTW'(ss), '0);
        chk_i("rst_cycles", longint'(cyc), 0);
        chk_i("rst_state", longint'(cst), 0);
        chk_i("rst_hash_en", longint'(bus.hash_en), 0);
        chk_i("rst_cpa_en", longint'(bus.cpa_en), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            for (int w = 0; w < PKW / 32; w++) vt[i].pk[w*32 +: 32] = $urandom;
            for (int w = 0; w < SW / 32; w++)  vt[i].coins[w*32 +: 32] = $urandom;
            ref_encaps(vt[i].pk, vt[i].coins, vt[i].ct, vt[i].ss);
        end

        for (int i = 0; i < 4; i++) begin
            start_run(vt[i].pk, vt[i].coins);
            wait_run(0);
            check_out($sformatf("t1_v%0d", i), vt[i].ct, vt[i].ss);
        end

        lat_fix = 40;
        start_run(vt[0].pk, vt[0].coins);
        wait_run(0);
        check_out("t3_ref", vt[0].ct, vt[0].ss);
        cyc_ref = longint'(cyc);
        tr_base = st_n;
        start_run(vt[0].pk, vt[0].coins);
        wait_run(50);
        check_out("t3_busy", vt[0].ct, vt[0].ss);
        chk_i("t3_cycles_same", longint'(cyc), cyc_ref);
        chk_i("t3_trace_len", st_n - tr_base, 5);
        for (int k = 0; k < 5; k++)
            chk_i($sformatf("t3_trace_%0d", k), longint'(st_log[(tr_base + k) % 4096]), exp_tr[k]);

        lat_fix = 10;
        start_run(vt[1].pk, vt[1].coins);
        wait_state(3'd1);
        cspur_req++;
        wait_state(3'd2);
        hspur_req++;
        wait_run(0);
        check_out("wrong_done", vt[1].ct, vt[1].ss);

        start_run(vt[2].pk, vt[2].coins);
        wait_state(3'd2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_i("t4_cal", longint'(cal), 0);
        chk_i("t4_done", longint'(done), 0);
        chk("t4_ct", ct, '0);
        chk("t4_ss", CTW'(ss), '0);
        chk_i("t4_cycles", longint'(cyc), 0);
        chk_i("t4_state", longint'(cst), 0);
        chk_i("t4_hash_en", longint'(bus.hash_en), 0);
        chk_i("t4_cpa_en", longint'(bus.cpa_en), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        lat_fix = 40;
        start_run(vt[0].pk, vt[0].coins);
        wait_run(0);
        check_out("t4_restart", vt[0].ct, vt[0].ss);
        chk_i("t4_cycles_same", longint'(cyc), cyc_ref);

        lat_fix = 0;
        start_run(vt[1].pk, vt[1].coins);
        wait_run(0);
        check_out("t5_first", vt[1].ct, vt[1].ss);
        start_run(vt[2].pk, vt[2].coins);
        chk_i("t5_done_drop", longint'(done_s), 0);
        chk_i("t5_cal_rise", longint'(cal_s), 1);
        wait_run(0);
        check_out("t5_second", vt[2].ct, vt[2].ss);

        sel4 = 1'b1;
        lat_fix = 10;
        start_run(vt[3].pk, vt[3].coins);
        wait_run(0);
        check_out("t6", vt[3].ct, vt[3].ss);
        chk_i("t6_cycles_sat", longint'(cyc4), 15);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
